// File: rtl/psola_playback.sv
// psola_playback: streams a PSOLA buffer out one sample per tick and zeroes each consumed word
module psola_playback #(
  parameter int WINDOW_SIZE = 2048,
  parameter int FRAC_BITS = 10,
  localparam int AW = $clog2(WINDOW_SIZE) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [11:0]   window_len_in,
  input  logic          window_len_valid_in,
  input  logic          sample_tick_in,
  output logic [AW-1:0] rd_addr_out,
  input  logic [31:0]   rd_data_in,
  output logic [AW-1:0] clr_addr_out,
  output logic          clr_en_out,
  output logic [15:0]   sample_out,
  output logic          sample_valid_out,
  output logic          busy_out,
  output logic          frame_done_out,
  output logic          underrun_out,
  output logic          frame_drop_out
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_RD1 = 3'd2, S_RD2 = 3'd3, S_CAP = 3'd4;
  logic [2:0] r_state;
  logic [AW-1:0] r_idx, r_len, r_rd_addr, r_clr_addr;
  logic [15:0] r_sample;
  logic r_valid, r_clr_en, r_done, r_underrun, r_drop;
  logic [2:0] r_idle_tick;
  logic [AW-1:0] w_len_clip, w_idx_nxt;
  logic signed [31:0] w_shift;
  logic [15:0] w_sat;
  // length clamp, next index and the fixed-point to 16-bit saturating conversion
  always_comb begin
    w_len_clip = ({20'd0, window_len_in} > 32'(WINDOW_SIZE)) ? AW'(WINDOW_SIZE) : AW'(window_len_in);
    w_idx_nxt = r_idx + AW'(1);
    w_shift = $signed(rd_data_in) >>> FRAC_BITS;
    w_sat = (w_shift > 32'sd32767) ? 16'h7fff : (w_shift < -32'sd32768) ? 16'h8000 : w_shift[15:0];
  end
  assign busy_out = r_state != S_IDLE;
  assign rd_addr_out = r_rd_addr;
  assign clr_addr_out = r_clr_addr;
  assign clr_en_out = r_clr_en;
  assign sample_out = r_sample;
  assign sample_valid_out = r_valid;
  assign frame_done_out = r_done;
  assign underrun_out = r_underrun;
  assign frame_drop_out = r_drop;
  // playback FSM; an idle tick rides a 3-stage delay so its zero sample keeps the normal T+4 latency
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_len <= '0;
      r_rd_addr <= '0;
      r_clr_addr <= '0;
      r_sample <= '0;
      r_valid <= 1'b0;
      r_clr_en <= 1'b0;
      r_done <= 1'b0;
      r_underrun <= 1'b0;
      r_drop <= 1'b0;
      r_idle_tick <= '0;
    end else begin
      r_valid <= r_idle_tick[2];
      r_clr_en <= 1'b0;
      r_done <= 1'b0;
      r_idle_tick <= {r_idle_tick[1:0], sample_tick_in && r_state == S_IDLE};
      if (r_idle_tick[2]) r_sample <= '0;
      if (sample_tick_in && r_state != S_WAIT) r_underrun <= 1'b1;
      if (window_len_valid_in && r_state != S_IDLE) r_drop <= 1'b1;
      case (r_state)
        S_IDLE: if (window_len_valid_in) begin
          if (window_len_in == 12'd0) r_done <= 1'b1;
          else begin
            r_len <= w_len_clip;
            r_idx <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: if (sample_tick_in) begin
          r_rd_addr <= r_idx;
          r_state <= S_RD1;
        end
        S_RD1: r_state <= S_RD2;
        S_RD2: r_state <= S_CAP;
        S_CAP: begin
          r_sample <= w_sat;
          r_valid <= 1'b1;
          r_clr_en <= 1'b1;
          r_clr_addr <= r_idx;
          r_idx <= w_idx_nxt;
          r_done <= w_idx_nxt == r_len;
          r_state <= (w_idx_nxt == r_len) ? S_IDLE : S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/psola_playback.md
PSOLA_PLAYBACK -- requirements
Module: psola_playback

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 2048, the processed-buffer depth in samples; AW = $clog2(WINDOW_SIZE)+1.
REQ-002 SHALL have parameter FRAC_BITS, default 10, the fixed-point fraction of buffer words.
REQ-003 SHALL have port clk_in  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-low reset.
REQ-005 SHALL have port window_len_in  input  12  number of valid processed samples in the buffer.
REQ-006 SHALL have port window_len_valid_in  input  1  one-cycle pulse qualifying window_len_in.
REQ-007 SHALL have port sample_tick_in  input  1  one-cycle pulse per output audio sample period.
REQ-008 SHALL have port rd_addr_out  output  AW  processed-buffer read address.
REQ-009 SHALL have port rd_data_in  input  32  signed buffer word; valid 2 cycles after rd_addr_out.
REQ-010 SHALL have port clr_addr_out  output  AW  buffer address to zero.
REQ-011 SHALL have port clr_en_out  output  1  write-enable of a zero word to clr_addr_out.
REQ-012 SHALL have port sample_out  output  16  signed output audio sample.
REQ-013 SHALL have port sample_valid_out  output  1  one-cycle pulse qualifying sample_out.
REQ-014 SHALL have port busy_out  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port frame_done_out  output  1  one-cycle pulse when the last sample of a frame is consumed.
REQ-016 SHALL have ports underrun_out and frame_drop_out  output  1 each  sticky error flags.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT_TICK, RD1, RD2, CAPTURE.
REQ-018 IDLE + window_len_valid_in SHALL latch len = min(window_len_in, WINDOW_SIZE), clear idx to 0, and go to WAIT_TICK.
REQ-019 IDLE + window_len_valid_in with window_len_in == 0 SHALL stay in IDLE and pulse frame_done_out on the next cycle.
REQ-020 WAIT_TICK + sample_tick_in SHALL register rd_addr_out <= idx and go to RD1; then RD1 -> RD2 -> CAPTURE unconditionally.
REQ-021 CAPTURE SHALL sample rd_data_in (the word for idx), arithmetic-shift it right by FRAC_BITS, saturate to [-32768, 32767], and register the result into sample_out.
REQ-022 CAPTURE SHALL register clr_en_out=1 and clr_addr_out=idx for exactly one cycle, so each consumed word is zeroed for the next overlap-add frame.
REQ-023 CAPTURE SHALL increment idx; if idx+1 == len it SHALL go to IDLE and pulse frame_done_out, else go to WAIT_TICK.
REQ-024 Latency SHALL be fixed: tick in cycle T -> rd_addr_out valid in T+1, data captured at the end of T+3, sample_valid_out and clr_en_out high in T+4 only.
REQ-025 A sample_tick_in in IDLE SHALL output sample_out=0 with sample_valid_out in T+4, SHALL set underrun_out, and SHALL issue no read or clear.
REQ-026 A sample_tick_in in RD1, RD2 or CAPTURE SHALL be dropped and SHALL set underrun_out; the required tick spacing is >= 4 cycles.
REQ-027 A window_len_valid_in outside IDLE SHALL be ignored and SHALL set frame_drop_out; the frame in progress continues unaffected.
REQ-028 A window_len_valid_in coincident with a CAPTURE that finishes the frame SHALL still be dropped (only IDLE accepts).
REQ-029 sample_valid_out, clr_en_out and frame_done_out SHALL each be single-cycle pulses; sample_out SHALL hold its value between pulses.
REQ-030 busy_out SHALL be combinational from state; all other outputs SHALL be registered.

Reset
REQ-031 rst_in low at a clock edge SHALL force IDLE; idx, len, rd_addr_out, clr_addr_out, sample_out = 0; and sample_valid_out, clr_en_out, frame_done_out, underrun_out, frame_drop_out = 0.
REQ-032 Reset mid-frame SHALL abort with no further reads or clears; unconsumed buffer words are not zeroed.
REQ-033 Sticky flags SHALL clear only on reset.

Verification
REQ-034 Scenario: len=3, words {0x400, 0xFFFFFC00, 0x7FFFFFFF}, ticks every 8 cycles -> samples 1, -1, 32767; clr_addr_out 0, 1, 2; frame_done_out with the third sample.
REQ-035 Scenario: word 0x80000000 -> sample_out = -32768; word 0x3FF -> 0.
REQ-036 Scenario: tick at T -> rd_addr_out valid at T+1, sample_valid_out at exactly T+4; a tick at T+2 sets underrun_out and adds no extra sample.
REQ-037 Scenario: window_len_valid_in mid-frame -> frame_drop_out=1 and the original length completes; window_len_in=0 -> frame_done_out next cycle, busy_out stays 0.
REQ-038 Scenario: window_len_in=4095 -> exactly 2048 samples, then frame_done_out.
REQ-039 Scenario: tick in IDLE -> sample_out=0, underrun_out=1; rst_in low during RD2 -> IDLE next cycle, no clr_en_out pulse.
